// File: rtl/mux_scan_sampler_pkg.sv
// Shared definitions for the mux scan sampler.
//   NUM_CH / SEL_W : channel count of the downstream mux and select width
//   state_e        : scan FSM state encoding
//   entry_state()  : first state of a channel, which depends on the settle time
package mux_scan_sampler_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2
    } state_e;

    // With no settle time, every cycle of a scan is a sample cycle.
    function automatic state_e entry_state(input int unsigned settle_cycles);
        return (settle_cycles == 0) ? StSample : StSettle;
    endfunction

endpackage

// File: rtl/mux_scan_sampler_if.sv
// Control/data bundle between the scan sampler and its user.
//   start, cont, abort : scan control (master -> slave)
//   mux_out            : output of the downstream 4:1 mux (master -> slave)
//   s0, s1             : mux selects (slave -> master)
//   busy, done, data   : scan status and captured word (slave -> master)
interface mux_scan_sampler_if;
    import mux_scan_sampler_pkg::*;

    logic              start;
    logic              cont;
    logic              abort;
    logic              mux_out;
    logic              s0;
    logic              s1;
    logic              busy;
    logic              done;
    logic [NUM_CH-1:0] data;

    modport master (
        output start, cont, abort, mux_out,
        input  s0, s1, busy, done, data
    );

    modport slave (
        input  start, cont, abort, mux_out,
        output s0, s1, busy, done, data
    );

endinterface

// File: rtl/mux_scan_sampler_settle_counter.sv
// Settle-time counter: clear has priority over load, load over increment.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force count to zero
//   load       : load load_val
//   inc        : increment by one
//   term_val   : terminal value compared against the current count
//   term       : high while count == term_val
module mux_scan_sampler_settle_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    input  logic [CNT_W-1:0] term_val,
    output logic             term
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == term_val);

endmodule

// File: rtl/mux_scan_sampler.sv
// Scans a 4:1 mux through channels 0..3, holding each select for SETTLE_CYCLES+1
// cycles and sampling on the last, then publishes all four samples at once with
// a one-cycle done strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mux_scan_sampler_if (control, mux_out, selects,
//                busy, done, data)
module mux_scan_sampler
    import mux_scan_sampler_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_scan_sampler_if.slave     bus
);

    localparam state_e FirstSt = entry_state(SETTLE_CYCLES);
    // Unused when SETTLE_CYCLES is 0 because SETTLE is never entered.
    localparam logic [CNT_W-1:0] TermVal =
        (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] LastCh = SEL_W'(NUM_CH - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NUM_CH-1:0] data_q, data_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;

    logic cnt_clr, cnt_load, cnt_inc, cnt_term;

    mux_scan_sampler_settle_counter #(
        .CNT_W (CNT_W)
    ) u_settle_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val ('0),
        .inc      (cnt_inc),
        .term_val (TermVal),
        .term     (cnt_term)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        data_d   = data_q;
        shadow_d = shadow_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;

        unique case (state_q)
            StIdle: begin
                ch_d   = '0;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = FirstSt;
                    busy_d  = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            StSettle: begin
                cnt_inc = 1'b1;
                if (cnt_term) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                shadow_d[ch_q] = bus.mux_out;
                cnt_load       = 1'b1;
                if (ch_q != LastCh) begin
                    ch_d    = ch_q + SEL_W'(1);
                    state_d = FirstSt;
                end else begin
                    // Publish the whole word in one edge so data never shows a partial scan.
                    data_d         = shadow_q;
                    data_d[LastCh] = bus.mux_out;
                    done_d         = 1'b1;
                    ch_d           = '0;
                    if (bus.cont) begin
                        state_d = FirstSt;
                    end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                ch_d    = '0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides sampling, completion and continuous restart.
        if (bus.abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            ch_d     = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            data_d   = data_q;
            shadow_d = '0;
            cnt_clr  = 1'b1;
            cnt_load = 1'b0;
            cnt_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
        end
    end

    assign bus.s0   = ch_q[0];
    assign bus.s1   = ch_q[1];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.data = data_q;

endmodule
